// File: rtl/axis_read_data_pkg.sv
// Shared types for the AXI read-data to stream bridge.
package axis_read_data_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'b0001,
      ST_ACTIVE = 4'b0010,
      ST_DRAIN  = 4'b0100,
      ST_DONE   = 4'b1000
   } state_e;

endpackage

// File: rtl/axis_read_data_fifo.sv
// Beat buffer: first-word-fall-through FIFO with a registered occupancy count.
module axis_read_data_fifo #(
   parameter int DWIDTH = 64,
   parameter int AWIDTH = 9
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DWIDTH-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DWIDTH-1:0] pop_data_o,
   output logic              full_o,
   output logic              empty_o
);
   localparam int unsigned       DEPTH    = 2 ** AWIDTH;
   localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH + 1)'(1);
   localparam logic [AWIDTH:0]   CNT_FULL = (AWIDTH + 1)'(DEPTH);
   localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [AWIDTH:0]   count_q;
   logic              do_push, do_pop;

   assign full_o     = (count_q == CNT_FULL);
   assign empty_o    = (count_q == '0);
   assign do_push    = push_i & ~full_o;
   assign do_pop     = pop_i & ~empty_o;
   assign pop_data_o = mem_q[rd_ptr_q];

   // NOTE: storage is deliberately left out of reset; only pointers and count define contents.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
         else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
      end
   end

endmodule

// File: rtl/axis_read_data_serializer.sv
// Splits one wide beat into DATA_NB narrow words, slice 0 first, with registered outputs.
module axis_read_data_serializer #(
   parameter int DATA_NB    = 2,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst_i,
   input  logic [DATA_NB*DATA_WIDTH-1:0] up_data_i,
   input  logic                          up_valid_i,
   output logic                          up_ready_o,
   input  logic                          last_i,
   output logic [DATA_WIDTH-1:0]         down_data_o,
   output logic                          down_valid_o,
   input  logic                          down_ready_i
);
   localparam int          SW         = (DATA_NB > 2) ? $clog2(DATA_NB) : 1;
   localparam logic [SW-1:0] SLICE_LAST = SW'(DATA_NB - 1);
   localparam logic [SW-1:0] SLICE_ONE  = SW'(1);

   logic [DATA_NB*DATA_WIDTH-1:0] shift_q;
   logic [SW-1:0]                 slice_q;
   logic                          valid_q;
   logic                          fire, final_slice, stop;

   assign fire         = valid_q & down_ready_i;
   assign final_slice  = (slice_q == SLICE_LAST);
   assign stop         = fire & last_i;
   // Refill overlaps the last slice so consecutive beats stream without bubbles.
   assign up_ready_o   = (~valid_q | (fire & final_slice)) & ~stop;
   assign down_data_o  = shift_q[DATA_WIDTH-1:0];
   assign down_valid_o = valid_q;

   // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         shift_q <= '0;
         slice_q <= '0;
         valid_q <= 1'b0;
      end else if (stop) begin
         valid_q <= 1'b0;
      end else if (up_ready_o && up_valid_i) begin
         shift_q <= up_data_i;
         slice_q <= '0;
         valid_q <= 1'b1;
      end else if (fire) begin
         if (final_slice) begin
            valid_q <= 1'b0;
         end else begin
            shift_q <= shift_q >> DATA_WIDTH;
            slice_q <= slice_q + SLICE_ONE;
         end
      end
   end

endmodule

// File: rtl/axis_read_data.sv
// AXI read-data channel to narrow valid/ready stream, delivering exactly cfg_length words.
module axis_read_data
   import axis_read_data_pkg::*;
#(
   parameter int BUF_AWIDTH     = 9,
   parameter int CONFIG_DWIDTH  = 32,
   parameter int WIDTH_RATIO    = 2,
   parameter int CONVERT_SHIFT  = 1,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
   input  logic                      axi_rlast,
   input  logic                      axi_rvalid,
   output logic                      axi_rready,
   output logic [DATA_WIDTH-1:0]     data,
   output logic                      valid,
   input  logic                      ready
);
   localparam logic [CONFIG_DWIDTH-1:0] CNT_ONE = CONFIG_DWIDTH'(1);

   state_e                    state_q;
   logic [CONFIG_DWIDTH-1:0]  beat_cnt_q, beat_last_q, str_cnt_q, str_last_q;
   logic [CONFIG_DWIDTH-1:0]  len_m1;
   logic [AXI_DATA_WIDTH-1:0] fifo_data;
   logic                      fifo_rst, fifo_full, fifo_empty, fifo_pop;
   logic                      beat_hs, str_hs, str_final;
   logic                      rlast_unused;

   assign rlast_unused = axi_rlast;
   assign len_m1       = cfg_length - CNT_ONE;
   assign cfg_ready    = (state_q == ST_IDLE);
   assign axi_rready   = (state_q == ST_ACTIVE) & ~fifo_full;
   assign beat_hs      = axi_rvalid & axi_rready;
   assign str_hs       = valid & ready;
   assign str_final    = (str_cnt_q == str_last_q);
   // Buffered beats and partial slices are discarded between transfers.
   assign fifo_rst     = rst | (state_q == ST_IDLE) | (state_q == ST_DONE);

   axis_read_data_fifo #(
      .DWIDTH (AXI_DATA_WIDTH),
      .AWIDTH (BUF_AWIDTH)
   ) u_fifo (
      .clk         (clk),
      .rst_i       (fifo_rst),
      .push_i      (beat_hs),
      .push_data_i (axi_rdata),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   axis_read_data_serializer #(
      .DATA_NB    (WIDTH_RATIO),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .clk          (clk),
      .rst_i        (fifo_rst),
      .up_data_i    (fifo_data),
      .up_valid_i   (~fifo_empty),
      .up_ready_o   (fifo_pop),
      .last_i       (str_final),
      .down_data_o  (data),
      .down_valid_o (valid),
      .down_ready_i (ready)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         beat_cnt_q  <= '0;
         beat_last_q <= '0;
         str_cnt_q   <= '0;
         str_last_q  <= '0;
      end else begin
         if (str_hs) str_cnt_q <= str_cnt_q + CNT_ONE;
         case (state_q)
            ST_IDLE: begin
               if (cfg_valid) begin
                  str_last_q  <= len_m1;
                  beat_last_q <= len_m1 >> CONVERT_SHIFT;
                  beat_cnt_q  <= '0;
                  str_cnt_q   <= '0;
                  state_q     <= (cfg_length == '0) ? ST_DONE : ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (beat_hs) begin
                  beat_cnt_q <= beat_cnt_q + CNT_ONE;
                  if (beat_cnt_q == beat_last_q) state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (str_hs && str_final) state_q <= ST_DONE;
            end
            ST_DONE:  state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_read_data.sv
// Directed bench for axis_read_data: ordering, partial beats, backpressure, reset and zero length.
module tb_axis_read_data;
   logic        clk;
   logic        rst;
   logic [31:0] cfg_length;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [63:0] axi_rdata;
   logic        axi_rlast;
   logic        axi_rvalid;
   logic        axi_rready;
   logic [31:0] data;
   logic        valid;
   logic        ready;

   int checks = 0;
   int errors = 0;
   int beats_seen;
   int words_seen;

   axis_read_data dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_length (cfg_length),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .axi_rdata  (axi_rdata),
      .axi_rlast  (axi_rlast),
      .axi_rvalid (axi_rvalid),
      .axi_rready (axi_rready),
      .data       (data),
      .valid      (valid),
      .ready      (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents the config in an idle cycle; the transfer loop drops cfg_valid next cycle.
   task automatic start_cfg(input logic [31:0] len);
      @(negedge clk);
      check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
      cfg_valid  = 1'b1;
      cfg_length = len;
   endtask

   // rmode: 0 ready high, 1 ready low for 600 cycles, 2 random. vmode: 0 rvalid high, 1 random.
   task automatic run_xfer(input int len, input logic [31:0] base, input int rmode, input int vmode,
                           input int stop_after, output int beats, output int words);
      int          cyc, first_cyc, last_cyc;
      bit          stall, finished;
      logic [31:0] held;
      beats = 0; words = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
      stall = 1'b0; finished = 1'b0; held = '0;
      while (!finished) begin
         @(negedge clk);
         cyc++;
         cfg_valid  = 1'b0;
         axi_rvalid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         axi_rdata  = {base + 32'(2 * beats + 1), base + 32'(2 * beats)};
         axi_rlast  = 1'b0;
         case (rmode)
            0:       ready = 1'b1;
            1:       ready = (cyc > 600);
            default: ready = 1'($urandom_range(0, 1));
         endcase
         if (stall) begin
            check("stall_valid_held", 32'(valid), 32'd1);
            check("stall_data_held", data, held);
         end
         stall = valid & ~ready;
         held  = data;
         if (rmode == 1 && cyc == 600) begin
            check("bp_beats_buffered", 32'(beats), 32'd513);
            check("bp_rready_low", 32'(axi_rready), 32'd0);
         end
         if (valid && ready) begin
            check("word_data", data, base + 32'(words));
            if (first_cyc < 0) first_cyc = cyc;
            words++;
            if (words == len && last_cyc < 0) last_cyc = cyc;
         end
         if (axi_rvalid && axi_rready) beats++;
         if (last_cyc > 0 && cyc == last_cyc + 1) begin
            check("done_cfg_ready_low", 32'(cfg_ready), 32'd0);
            check("done_valid_low", 32'(valid), 32'd0);
         end else if (last_cyc > 0 && cyc == last_cyc + 2) begin
            check("cfg_ready_back", 32'(cfg_ready), 32'd1);
            finished = 1'b1;
         end
         if (stop_after > 0 && words == stop_after) finished = 1'b1;
         if (cyc >= 6000) begin
            check("timeout_words", 32'(words), 32'(len));
            finished = 1'b1;
         end
      end
      if (stop_after == 0) begin
         check("word_count", 32'(words), 32'(len));
         if (rmode == 0 && vmode == 0) begin
            check("first_word_latency", 32'(first_cyc), 32'd3);
            check("one_word_per_cycle", 32'(last_cyc - first_cyc), 32'(len - 1));
         end
      end
   endtask

   initial begin
      rst = 1'b1; cfg_length = '0; cfg_valid = 1'b0;
      axi_rdata = '0; axi_rlast = 1'b0; axi_rvalid = 1'b0; ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      check("rst_rready", 32'(axi_rready), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_data", data, 32'd0);
      rst = 1'b0;

      // Whole beats: 4 beats, words 0..7 back to back.
      start_cfg(32'd8);
      run_xfer(8, 32'h0, 0, 0, 0, beats_seen, words_seen);
      check("len8_beats", 32'(beats_seen), 32'd4);

      // Partial final beat: upper slice of third beat never shown, fourth beat left pending.
      start_cfg(32'd5);
      run_xfer(5, 32'h1000, 0, 0, 0, beats_seen, words_seen);
      check("len5_beats", 32'(beats_seen), 32'd3);
      check("len5_rready_after", 32'(axi_rready), 32'd0);

      // Zero length: straight to DONE, nothing moves.
      start_cfg(32'd0);
      @(negedge clk);
      cfg_valid = 1'b0; axi_rvalid = 1'b1; ready = 1'b1;
      check("zero_cfg_ready_low", 32'(cfg_ready), 32'd0);
      check("zero_rready", 32'(axi_rready), 32'd0);
      check("zero_valid", 32'(valid), 32'd0);
      @(negedge clk);
      check("zero_cfg_ready_back", 32'(cfg_ready), 32'd1);
      check("zero_rready2", 32'(axi_rready), 32'd0);
      check("zero_valid2", 32'(valid), 32'd0);

      // Backpressure: buffer fills to 512 beats plus one in the serializer.
      start_cfg(32'd2048);
      run_xfer(2048, 32'h2000, 1, 0, 0, beats_seen, words_seen);
      check("bp_beats", 32'(beats_seen), 32'd1024);

      // Reset mid-transfer after the third word.
      start_cfg(32'd8);
      run_xfer(8, 32'h8000, 0, 0, 3, beats_seen, words_seen);
      rst = 1'b1;
      @(negedge clk);
      axi_rvalid = 1'b0;
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_rready", 32'(axi_rready), 32'd0);
      check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
      rst = 1'b0;
      start_cfg(32'd4);
      run_xfer(4, 32'h9000, 0, 0, 0, beats_seen, words_seen);
      check("post_rst_beats", 32'(beats_seen), 32'd2);

      // Random gaps on both sides, then a fresh transfer to expose stale data.
      start_cfg(32'd37);
      run_xfer(37, 32'hA000, 2, 1, 0, beats_seen, words_seen);
      check("rand_beats", 32'(beats_seen), 32'd19);
      start_cfg(32'd4);
      run_xfer(4, 32'hB000, 0, 0, 0, beats_seen, words_seen);
      check("fresh_beats", 32'(beats_seen), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
